// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares the byte-wide RAM/IO bus between instruction fetch and
//               the load/store stage. Splits 1/2/4-byte requests into
//               little-endian byte accesses pipelined against the RAM read
//               latency, honours the rdy pause and supports fetch abort.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_inst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_READ  = 2'd1;
    localparam logic [1:0] c_ST_WRITE = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_owner_if;   // 1 = fetch owns the bus, 0 = load/store
    logic [ADDR_W-1:0] r_base;
    logic [1:0]        r_last;       // index of the final byte (n-1)
    logic [1:0]        r_k;          // issue index
    logic [31:0]       r_wdata;
    logic [1:0]        r_lat_idx;    // byte index the RAM latched last edge
    logic              r_lat_valid;
    logic [31:0]       r_bytes;

    logic              w_grant;
    logic              w_abort;
    logic              w_rd_last;
    logic              w_wr_last;
    logic              w_step;
    logic [1:0]        w_grant_last;
    logic [1:0]        w_k_inc;
    logic [ADDR_W-1:0] w_k_ext;
    logic [31:0]       w_bytes;
    logic [31:0]       w_masked;

    assign w_grant   = (r_state == c_ST_IDLE) && rdy && (mem_req || if_req);
    assign w_abort   = (r_state == c_ST_READ) && rdy && r_owner_if && !if_req;
    assign w_rd_last = (r_state == c_ST_READ) && rdy && !w_abort &&
                       r_lat_valid && (r_lat_idx == r_last);
    assign w_wr_last = (r_state == c_ST_WRITE) && rdy && (r_k == r_last);
    assign w_step    = rdy && ((r_state == c_ST_READ) || (r_state == c_ST_WRITE)) &&
                       (r_k != r_last);
    assign w_k_inc   = r_k + 2'd1;
    assign w_k_ext   = {{(ADDR_W-2){1'b0}}, w_k_inc};

    // Byte count of the request being granted: fetch is always a word,
    // and a length code of 2 is promoted to a full word.
    always_comb begin
        w_grant_last = 2'd3;
        if (mem_req) begin
            case (mem_len)
                2'd0:    w_grant_last = 2'd0;
                2'd1:    w_grant_last = 2'd1;
                default: w_grant_last = 2'd3;
            endcase
        end
    end

    // Assembled read word with the byte currently on ram_din merged in.
    always_comb begin
        w_bytes = r_bytes;
        if (r_lat_valid) begin
            w_bytes[{r_lat_idx, 3'b000} +: 8] = ram_din;
        end
    end

    // Load result with bytes beyond the requested length forced to zero.
    always_comb begin
        w_masked = '0;
        for (int i = 0; i < 4; i++) begin
            if (2'(i) <= r_last) begin
                w_masked[i*8 +: 8] = w_bytes[i*8 +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; every transition waits for an edge with rdy high.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_grant) w_state_nxt = (mem_req && mem_we) ? c_ST_WRITE : c_ST_READ;
            c_ST_READ: begin
                if (w_abort)        w_state_nxt = c_ST_IDLE;
                else if (w_rd_last) w_state_nxt = c_ST_DONE;
            end
            c_ST_WRITE: if (w_wr_last) w_state_nxt = c_ST_DONE;
            c_ST_DONE:  if (rdy) w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Outputs decoded from state; the write strobe drops as soon as rdy does.
    always_comb begin
        if_done  = (r_state == c_ST_DONE) && r_owner_if;
        mem_done = (r_state == c_ST_DONE) && !r_owner_if;
        ram_wr   = (r_state == c_ST_WRITE) && rdy;
    end

    // Datapath: grant capture, byte sequencing and read assembly.
    // The RAM latches its address on every edge regardless of rdy, so the
    // latency tracker and byte capture also run on paused edges; otherwise
    // the byte already in flight when rdy drops would be lost. Re-capturing
    // the same byte while paused rewrites an identical value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner_if  <= 1'b0;
            r_base      <= '0;
            r_last      <= '0;
            r_k         <= '0;
            r_wdata     <= '0;
            r_lat_idx   <= '0;
            r_lat_valid <= 1'b0;
            r_bytes     <= '0;
            ram_a       <= '0;
            ram_dout    <= '0;
            if_inst     <= '0;
            mem_rdata   <= '0;
        end else begin
            r_lat_idx   <= r_k;
            r_lat_valid <= (r_state == c_ST_READ);
            if ((r_state == c_ST_READ) && r_lat_valid) begin
                r_bytes <= w_bytes;
            end
            if (w_grant) begin
                r_owner_if <= !mem_req;
                r_base     <= mem_req ? mem_addr : if_addr;
                ram_a      <= mem_req ? mem_addr : if_addr;
                r_last     <= w_grant_last;
                r_k        <= 2'd0;
                r_wdata    <= mem_wdata;
                ram_dout   <= (mem_req && mem_we) ? mem_wdata[7:0] : 8'h00;
            end else if (w_abort) begin
                ram_a <= '0;
            end else if (w_rd_last) begin
                ram_a <= '0;
                if (r_owner_if) begin
                    if_inst <= w_bytes;
                end else begin
                    mem_rdata <= w_masked;
                end
            end else if (w_wr_last) begin
                ram_a    <= '0;
                ram_dout <= '0;
            end else if (w_step) begin
                r_k   <= w_k_inc;
                ram_a <= r_base + w_k_ext;
                if (r_state == c_ST_WRITE) begin
                    ram_dout <= r_wdata[{w_k_inc, 3'b000} +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire
